// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp encodings and pedestrian FSM state type shared by the ped_signal slice
package traffic_pkg;
   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;
   typedef enum logic [2:0] {IDLE, WAIT, WALK, CLEAR, FAULT} ped_state_t;
   function automatic logic lamp_ok(input logic [2:0] l);
      return l == RED || l == YELLOW || l == GREEN;
   endfunction
endpackage

// File: rtl/ped_debounce.sv
// ped_debounce: 2-flop synchronizer plus debouncer that accepts a level after DEBOUNCE_CYCLES equal samples
module ped_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic s1, s2;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         cnt  <= '0;
         dout <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         if (s2 == dout)
            cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt  <= '0;
            dout <= s2;
         end else
            cnt <= cnt + CW'(1);
      end
endmodule

// File: rtl/ped_signal.sv
// ped_signal: pedestrian crossing controller slaved to the road-A red phase of traffic_light
module ped_signal
   import traffic_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 20,
   parameter int unsigned WALK_CYCLES     = 10,
   parameter int unsigned CLEAR_CYCLES    = 8,
   parameter int unsigned FLASH_HALF      = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   input  logic [2:0] light_A,
   input  logic [2:0] light_B,
   output logic       walk,
   output logic       dont_walk,
   output logic [7:0] countdown,
   output logic       req_pending,
   output logic       abort,
   output logic       fault
);
   localparam int WW = $clog2(WALK_CYCLES + 1);
   localparam int FW = $clog2(FLASH_HALF + 1);
   ped_state_t state, nxt;
   logic db, db_q, a_red_q, flash;
   logic [WW-1:0] tmr;
   logic [FW-1:0] fcnt;
   logic [7:0] cd;
   logic a_red, illegal, red_rise, db_rise, cut;
   ped_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (clk),
      .rst (rst),
      .din (btn),
      .dout(db)
   );
   assign a_red    = light_A == RED;
   assign illegal  = !lamp_ok(light_A) || !lamp_ok(light_B) || (!a_red && light_B != RED);
   assign red_rise = a_red && !a_red_q;
   assign db_rise  = db && !db_q;
   assign cut      = (state == WALK || state == CLEAR) && !a_red;
   always_comb begin
      nxt = state;
      if (illegal)
         nxt = FAULT;
      else
         case (state)
            IDLE:    nxt = req_pending ? WAIT : IDLE;
            WAIT:    nxt = red_rise ? WALK : WAIT;
            WALK:    nxt = !a_red ? IDLE : tmr == WW'(WALK_CYCLES - 1) ? CLEAR : WALK;
            CLEAR:   nxt = !a_red ? IDLE : cd == 8'd1 ? (req_pending ? WAIT : IDLE) : CLEAR;
            default: nxt = FAULT;
         endcase
   end
   // a fresh press wins over the clear-on-service so it is never lost
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state       <= IDLE;
         db_q        <= 1'b0;
         a_red_q     <= 1'b0;
         req_pending <= 1'b0;
         abort       <= 1'b0;
         tmr         <= '0;
         cd          <= '0;
         fcnt        <= '0;
         flash       <= 1'b1;
      end else begin
         state       <= nxt;
         db_q        <= db;
         a_red_q     <= a_red;
         abort       <= cut && !illegal;
         req_pending <= db_rise || (req_pending && !(state == WAIT && nxt == WALK));
         tmr         <= state == WALK ? tmr + WW'(1) : '0;
         cd          <= nxt == CLEAR ? (state == CLEAR ? cd - 8'd1 : 8'(CLEAR_CYCLES)) : 8'd0;
         if (state != CLEAR) begin
            fcnt  <= '0;
            flash <= 1'b1;
         end else if (fcnt == FW'(FLASH_HALF - 1)) begin
            fcnt  <= '0;
            flash <= !flash;
         end else
            fcnt <= fcnt + FW'(1);
      end
   assign walk      = state == WALK;
   assign dont_walk = state == WALK ? 1'b0 : state == CLEAR ? flash : 1'b1;
   assign countdown = cd;
   assign fault     = state == FAULT;
endmodule

// File: doc/ped_signal.md
PED_SIGNAL -- requirements
Module: ped_signal

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20, meaning consecutive stable cycles required to accept a button level change.
REQ-002 Parameter WALK_CYCLES, default 10, meaning duration of the solid WALK phase in clocks.
REQ-003 Parameter CLEAR_CYCLES, default 8 (range 1..255), meaning duration of the flashing clearance phase in clocks.
REQ-004 Parameter FLASH_HALF, default 1, meaning clocks per half-period of the clearance flash.
REQ-005 Port clk, input, 1, meaning the single clock; all state is updated on its rising edge.
REQ-006 Port rst, input, 1, meaning the reset; it is asynchronous and active-low.
REQ-007 Port btn, input, 1, meaning the raw asynchronous pedestrian push-button, active-high.
REQ-008 Port light_A, input, 3, meaning the road-A lamp from traffic_light: 3'b100 red, 3'b010 yellow, 3'b001 green.
REQ-009 Port light_B, input, 3, meaning the road-B lamp, with the same encoding as light_A.
REQ-010 Port walk, output, 1, meaning the WALK lamp for crossing road A.
REQ-011 Port dont_walk, output, 1, meaning the DON'T-WALK lamp, solid or flashing.
REQ-012 Port countdown, output, 8, meaning clearance clocks remaining; 0 outside CLEAR.
REQ-013 Port req_pending, output, 1, meaning an accepted request is awaiting service.
REQ-014 Port abort, output, 1, meaning a one-cycle pulse when a walk cycle is cut short.
REQ-015 Port fault, output, 1, meaning an illegal lamp input was detected; sticky.

Function
REQ-016 btn shall pass through a 2-flop synchronizer, then a debouncer whose stable level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-017 A rising edge of the debounced level shall set req_pending on the next clock; total btn-to-req_pending latency shall be DEBOUNCE_CYCLES+3 clocks at most.
REQ-018 The FSM shall have the states IDLE, WAIT, WALK, CLEAR and FAULT.
REQ-019 IDLE->WAIT when req_pending=1.
REQ-020 WAIT->WALK only on the first cycle light_A==RED after a non-red cycle (red rising edge); a request arriving mid-red waits for the next red phase.
REQ-021 Entering WALK shall clear req_pending in the same edge; a press during WALK or CLEAR sets req_pending again.
REQ-022 WALK lasts exactly WALK_CYCLES clocks, then ->CLEAR; CLEAR lasts exactly CLEAR_CYCLES clocks, then ->WAIT if req_pending else IDLE.
REQ-023 In CLEAR, countdown shall load CLEAR_CYCLES on entry and decrement each clock, reaching 1 in the last CLEAR cycle; dont_walk shall toggle every FLASH_HALF clocks, starting at 1.
REQ-024 Outputs: walk=1, dont_walk=0 only in WALK; dont_walk=1 solid in IDLE, WAIT and FAULT.
REQ-025 In WALK or CLEAR, light_A!=RED shall force ->IDLE on the next edge with abort=1 for that one cycle; req_pending is unaffected.
REQ-026 A non-one-hot light_A or light_B, or both lamps non-red in the same cycle, shall force ->FAULT from any state; FAULT exits only on reset.
REQ-027 A debounced edge coinciding with an abort or fault shall still set req_pending; FAULT masks it from service.

Reset
REQ-028 While rst=0: FSM=IDLE, walk=0, dont_walk=1, countdown=0, req_pending=0, abort=0, fault=0, synchronizer and debounced level=0, and counters=0.
REQ-029 Reset asserted mid-walk shall drop walk within the same cycle, asynchronously.

Structure
REQ-030 The shared package traffic_pkg shall hold the lamp encodings RED/YELLOW/GREEN and the ped_state_t enum.
REQ-031 The synchronizer and debouncer shall be the sub-module ped_debounce (clk, rst, din, dout).

Verification (DEBOUNCE_CYCLES=4, WALK_CYCLES=6, CLEAR_CYCLES=4, FLASH_HALF=1)
REQ-032 Press btn for 10 clocks with light_A green, then give light_A a red edge -> req_pending within 7 clocks; walk=1 for exactly 6 clocks from the red edge; countdown 4,3,2,1; dont_walk 1,0,1,0; then IDLE.
REQ-033 Apply 2-clock btn glitches repeated 5 times -> req_pending stays 0.
REQ-034 Request while light_A is already red -> no walk in that red phase; walk starts on the next red rising edge.
REQ-035 light_A goes green on the 3rd WALK cycle -> walk=0 and abort=1 on the next edge, with abort high for one cycle.
REQ-036 Drive light_B=3'b011 -> fault=1 and dont_walk=1 held through later presses until rst=0.
REQ-037 Drop rst to 0 mid-CLEAR -> all outputs at reset values immediately, with no clock required.
